// File: rtl/wb_arbiter.sv
// wb_arbiter: N-source register-file writeback arbiter. Each source owns a
// one-entry holding slot; one slot per cycle is granted into a registered
// single write port (fixed priority with starvation override, or round-robin).
module wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 3,
  parameter int NUM_SRC  = 2,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*REG_AW-1:0] src_dest,
  output logic                      wb_write,
  output logic [DATA_W-1:0]         wb_data,
  output logic [REG_AW-1:0]         wb_dest,
  output logic [$clog2(NUM_SRC)-1:0] wb_src,
  output logic                      wb_conflict,
  output logic [NUM_SRC-1:0]        pending
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // Holding slots
  logic [NUM_SRC-1:0] full_q, full_d;
  logic [DATA_W-1:0]  data_q [NUM_SRC];
  logic [DATA_W-1:0]  data_d [NUM_SRC];
  logic [REG_AW-1:0]  dest_q [NUM_SRC];
  logic [REG_AW-1:0]  dest_d [NUM_SRC];
  logic [WAIT_W-1:0]  wait_q [NUM_SRC];
  logic [WAIT_W-1:0]  wait_d [NUM_SRC];
  logic [SRC_W-1:0]   rr_q, rr_d;

  // Output register
  logic               wb_write_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic [REG_AW-1:0]  wb_dest_q;
  logic [SRC_W-1:0]   wb_src_q;
  logic               wb_conflict_q;

  logic [NUM_SRC-1:0] grant, load;
  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_idx;
  logic               conflict_d;

  // Grant selection from slot state only
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!gnt_any && full_q[i] && (wait_q[i] == WAIT_W'(MAX_WAIT))) begin
          gnt_any = 1'b1;
          gnt_idx = SRC_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!gnt_any && full_q[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SRC_W'(i);
        end
      end
    end else begin
      // Wrapped search split into two ascending passes: [rr..N-1] then [0..rr-1]
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!gnt_any && full_q[i] && (SRC_W'(i) >= rr_q)) begin
          gnt_any = 1'b1;
          gnt_idx = SRC_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!gnt_any && full_q[i] && (SRC_W'(i) < rr_q)) begin
          gnt_any = 1'b1;
          gnt_idx = SRC_W'(i);
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // Handshake, slot next-state, pointer and conflict detection
  always_comb begin
    src_ready  = rst ? '0 : (~full_q | grant);
    load       = src_valid & src_ready;
    full_d     = full_q;
    rr_d       = rr_q;
    conflict_d = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      data_d[i] = data_q[i];
      dest_d[i] = dest_q[i];
      wait_d[i] = wait_q[i];
      if (load[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = src_data[i*DATA_W +: DATA_W];
        dest_d[i] = src_dest[i*REG_AW +: REG_AW];
        wait_d[i] = '0;
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
        wait_d[i] = '0;
      end else if (full_q[i] && (wait_q[i] != WAIT_W'(MAX_WAIT))) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
    if (gnt_any) begin
      rr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if ((SRC_W'(j) != gnt_idx) && full_q[j] && !load[j] &&
            (dest_q[j] == dest_q[gnt_idx]))
          conflict_d = 1'b1;
      end
    end
  end

  // Slot, wait-counter and pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      rr_q   <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      rr_q   <= rr_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= data_d[i];
        dest_q[i] <= dest_d[i];
        wait_q[i] <= wait_d[i];
      end
    end
  end

  // Registered write port; payload holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_write_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_dest_q     <= '0;
      wb_src_q      <= '0;
      wb_conflict_q <= 1'b0;
    end else begin
      wb_write_q    <= gnt_any;
      wb_conflict_q <= conflict_d;
      if (gnt_any) begin
        wb_data_q <= data_q[gnt_idx];
        wb_dest_q <= dest_q[gnt_idx];
        wb_src_q  <= gnt_idx;
      end
    end
  end

  assign wb_write    = wb_write_q;
  assign wb_data     = wb_data_q;
  assign wb_dest     = wb_dest_q;
  assign wb_src      = wb_src_q;
  assign wb_conflict = wb_conflict_q;
  assign pending     = full_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: two arbiter instances (fixed priority N=2, round-robin N=3)
// driven with directed and random traffic and compared every cycle against a
// behavioural model of the arbitration rules.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: mode 0, NUM_SRC=2, MAX_WAIT=4
  logic [1:0]  v0, r0, p0;
  logic [15:0] d0;
  logic [5:0]  a0;
  logic        w0, ws0, c0;
  logic [7:0]  wd0;
  logic [2:0]  wa0;
  // Instance 1: mode 1, NUM_SRC=3
  logic [2:0]  v1, r1, p1;
  logic [23:0] d1;
  logic [8:0]  a1;
  logic        w1, c1;
  logic [1:0]  ws1;
  logic [7:0]  wd1;
  logic [2:0]  wa1;

  wb_arbiter #(.DATA_W(8), .REG_AW(3), .NUM_SRC(2), .ARB_MODE(0), .MAX_WAIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .src_valid(v0), .src_ready(r0), .src_data(d0), .src_dest(a0),
    .wb_write(w0), .wb_data(wd0), .wb_dest(wa0), .wb_src(ws0), .wb_conflict(c0), .pending(p0));

  wb_arbiter #(.DATA_W(8), .REG_AW(3), .NUM_SRC(3), .ARB_MODE(1), .MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .src_valid(v1), .src_ready(r1), .src_data(d1), .src_dest(a1),
    .wb_write(w1), .wb_data(wd1), .wb_dest(wa1), .wb_src(ws1), .wb_conflict(c1), .pending(p1));

  // Stimulus tables [instance][source]
  bit       iv [2][3];
  bit [7:0] id [2][3];
  bit [2:0] ia [2][3];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      v0[i]         = iv[0][i];
      d0[i*8 +: 8]  = id[0][i];
      a0[i*3 +: 3]  = ia[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      v1[i]         = iv[1][i];
      d1[i*8 +: 8]  = id[1][i];
      a1[i*3 +: 3]  = ia[1][i];
    end
  end

  // Reference model state
  bit       m_full [2][3];
  bit [7:0] m_data [2][3];
  bit [2:0] m_dest [2][3];
  int       m_wt   [2][3];
  int       m_rr   [2];
  bit       m_wr   [2];
  bit [7:0] m_wd   [2];
  bit [2:0] m_wa   [2];
  int       m_ws   [2];
  bit       m_cf   [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int n_of(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  // Which slot the arbitration rules pick, or -1 when every slot is empty
  function automatic int pick(input int u);
    int n = n_of(u);
    if (u == 0) begin
      for (int i = 0; i < n; i++) if (m_full[u][i] && m_wt[u][i] == 4) return i;
      for (int i = 0; i < n; i++) if (m_full[u][i]) return i;
    end else begin
      for (int o = 0; o < n; o++) begin
        int k = (m_rr[u] + o) % n;
        if (m_full[u][k]) return k;
      end
    end
    return -1;
  endfunction

  task automatic step(input int u);
    int n = n_of(u);
    int g;
    bit ld [3];
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_full[u][i] = 0; m_data[u][i] = 0; m_dest[u][i] = 0; m_wt[u][i] = 0;
      end
      m_rr[u] = 0; m_wr[u] = 0; m_wd[u] = 0; m_wa[u] = 0; m_ws[u] = 0; m_cf[u] = 0;
    end else begin
      g = pick(u);
      for (int i = 0; i < 3; i++) ld[i] = (i < n) && iv[u][i] && (!m_full[u][i] || g == i);
      m_cf[u] = 0;
      m_wr[u] = (g >= 0);
      if (g >= 0) begin
        for (int j = 0; j < n; j++)
          if (j != g && m_full[u][j] && !ld[j] && m_dest[u][j] == m_dest[u][g]) m_cf[u] = 1;
        m_wd[u] = m_data[u][g];
        m_wa[u] = m_dest[u][g];
        m_ws[u] = g;
        m_rr[u] = (g + 1) % n;
      end
      for (int i = 0; i < n; i++) begin
        if (ld[i]) begin
          m_full[u][i] = 1; m_data[u][i] = id[u][i]; m_dest[u][i] = ia[u][i]; m_wt[u][i] = 0;
        end else if (g == i) begin
          m_full[u][i] = 0; m_wt[u][i] = 0;
        end else if (m_full[u][i] && m_wt[u][i] < 4) begin
          m_wt[u][i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < 2; u++) begin
      int g = pick(u);
      logic [31:0] er = '0, ep = '0;
      logic [31:0] gr, gp, gw, gd, ga, gs, gc;
      for (int i = 0; i < n_of(u); i++) begin
        ep[i] = m_full[u][i];
        er[i] = !rst && (!m_full[u][i] || g == i);
      end
      if (u == 0) begin
        gr = 32'(r0); gp = 32'(p0); gw = 32'(w0); gd = 32'(wd0); ga = 32'(wa0); gs = 32'(ws0); gc = 32'(c0);
      end else begin
        gr = 32'(r1); gp = 32'(p1); gw = 32'(w1); gd = 32'(wd1); ga = 32'(wa1); gs = 32'(ws1); gc = 32'(c1);
      end
      check($sformatf("u%0d.src_ready", u), gr, er);
      check($sformatf("u%0d.pending", u), gp, ep);
      check($sformatf("u%0d.wb_write", u), gw, 32'(m_wr[u]));
      check($sformatf("u%0d.wb_data", u), gd, 32'(m_wd[u]));
      check($sformatf("u%0d.wb_dest", u), ga, 32'(m_wa[u]));
      check($sformatf("u%0d.wb_src", u), gs, 32'(m_ws[u]));
      check($sformatf("u%0d.wb_conflict", u), gc, 32'(m_cf[u]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step(0);
    step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input int u, input int i, input bit v, input bit [7:0] d, input bit [2:0] a);
    iv[u][i] = v; id[u][i] = d; ia[u][i] = a;
  endtask

  task automatic clear_in();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 3; i++) set_in(u, i, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with every source requesting
    rst = 1'b1;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 3; i++) set_in(u, i, 1'b1, 8'($urandom), 3'($urandom));
    repeat (3) begin
      tick();
      check("rst.ready0", 32'(r0), 32'h0);
      check("rst.write0", 32'(w0), 32'h0);
      check("rst.pending1", 32'(p1), 32'h0);
    end
    rst = 1'b0;
    tick();
    check("first_accept.pending0", 32'(p0), 32'h3);
    check("first_accept.pending1", 32'(p1), 32'h7);

    // Single source, two-cycle latency
    do_reset();
    set_in(0, 0, 1'b1, 8'hA5, 3'd3);
    tick();
    clear_in();
    tick();
    check("single.write", 32'(w0), 32'h1);
    check("single.data", 32'(wd0), 32'hA5);
    check("single.dest", 32'(wa0), 32'h3);
    check("single.src", 32'(ws0), 32'h0);
    tick();
    check("single.pulse_end", 32'(w0), 32'h0);

    // Fixed-priority starvation override
    do_reset();
    set_in(0, 0, 1'b1, 8'($urandom), 3'd1);
    set_in(0, 1, 1'b1, 8'h3C, 3'd5);
    tick();
    set_in(0, 1, 1'b0, 8'h00, 3'd0);
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1'b1, 8'($urandom), 3'd1);
      tick();
      check("starve.passover_src", 32'(ws0), 32'h0);
    end
    check("starve.ready0_low", 32'(r0[0]), 32'h0);
    tick();
    check("starve.grant_src", 32'(ws0), 32'h1);
    check("starve.grant_data", 32'(wd0), 32'h3C);
    check("starve.grant_dest", 32'(wa0), 32'h5);
    clear_in();
    tick();

    // Round-robin with all three sources streaming
    do_reset();
    for (int i = 0; i < 3; i++) set_in(1, i, 1'b1, 8'($urandom), 3'($urandom));
    tick();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) set_in(1, i, 1'b1, 8'($urandom), 3'($urandom));
      tick();
      check("rr.write", 32'(w1), 32'h1);
      check("rr.src", 32'(ws1), 32'(k % 3));
    end

    // Same destination loaded on the same edge
    do_reset();
    set_in(0, 0, 1'b1, 8'h11, 3'd2);
    set_in(0, 1, 1'b1, 8'h22, 3'd2);
    tick();
    clear_in();
    tick();
    check("conflict.first_src", 32'(ws0), 32'h0);
    check("conflict.first_data", 32'(wd0), 32'h11);
    check("conflict.first_flag", 32'(c0), 32'h1);
    tick();
    check("conflict.second_src", 32'(ws0), 32'h1);
    check("conflict.second_data", 32'(wd0), 32'h22);
    check("conflict.second_flag", 32'(c0), 32'h0);

    // Reset with full slots discards them
    do_reset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 3; i++) set_in(u, i, 1'b1, 8'($urandom), 3'($urandom));
    tick();
    clear_in();
    check("midrst.full_before", 32'(p0), 32'h3);
    rst = 1'b1;
    tick();
    check("midrst.write0_during", 32'(w0), 32'h0);
    check("midrst.write1_during", 32'(w1), 32'h0);
    check("midrst.pending0", 32'(p0), 32'h0);
    rst = 1'b0;
    tick();
    check("midrst.write0_after", 32'(w0), 32'h0);
    check("midrst.pending1_after", 32'(p1), 32'h0);

    // Random traffic with a narrow destination range and sporadic resets
    repeat (3000) begin
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 3; i++)
          set_in(u, i, ($urandom_range(0, 9) < 6), 8'($urandom), 3'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- N-source register-file writeback arbiter; parametrised successor to the 2:1 writeback select.
- Each source owns a one-entry holding slot with a valid/ready handshake.
- Exactly one write per cycle is granted (fixed priority with anti-starvation, or round-robin) and drives a registered single write port into the register file.
- Sits between the pipeline WB stage, matrix output unit and further writeback producers, and the 8-bit register file.

Parameters:
- DATA_W, 8, write data width
- REG_AW, 3, destination register address width
- NUM_SRC, 2, number of writeback sources (>=2); index 0 = normal pipeline
- ARB_MODE, 0, 0 = fixed priority (lowest index wins) with starvation override; 1 = round-robin
- MAX_WAIT, 4, cycles a full slot may be passed over before it is starved (>=1; used in mode 0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- src_valid  in  NUM_SRC  per-source write request
- src_ready  out  NUM_SRC  per-source slot can accept this cycle
- src_data  in  NUM_SRC*DATA_W  packed write data; source i at [i*DATA_W +: DATA_W]
- src_dest  in  NUM_SRC*REG_AW  packed destination register; source i at [i*REG_AW +: REG_AW]
- wb_write  out  1  registered register-file write enable
- wb_data  out  DATA_W  registered write data
- wb_dest  out  REG_AW  registered destination register
- wb_src  out  clog2(NUM_SRC)  index of the granted source
- wb_conflict  out  1  registered; granted dest matched another still-pending slot
- pending  out  NUM_SRC  slot-full flags

Behaviour:
- Reset (rst high at edge):
  - All slots are emptied and all wait counters cleared.
  - The RR pointer is set to 0.
  - wb_write=0, wb_data=0, wb_dest=0, wb_src=0, wb_conflict=0, pending=0.
  - src_ready is forced 0 while rst is high.
  - Reset mid-operation discards all pending writes; no write is emitted.
- Handshake:
  - Source i transfers when src_valid[i] && src_ready[i] at a rising edge.
  - src_ready[i] = !full[i] || grant[i]. Combinational from slot state only, never from src_valid.
  - Load and grant on the same source in the same cycle: the old entry goes to the output and the new entry occupies the slot. Wait counter goes to 0.
- Grant is combinational from slot state; at most one grant per cycle; no grant when all slots are empty.
- Mode 0:
  - If any full slot has wait==MAX_WAIT, grant the lowest such index.
  - Otherwise grant the lowest-index full slot.
- Mode 1:
  - Search full slots starting at the RR pointer, wrapping modulo NUM_SRC.
  - After a grant to k, the pointer becomes (k+1) mod NUM_SRC.
  - The pointer holds when there is no grant.
- Wait counters:
  - Cleared on slot load.
  - Increment while the slot is full and not granted; saturate at MAX_WAIT.
  - Width is clog2(MAX_WAIT+1).
  - Mode 1: maintained but ignored.
- Output register, updated every edge:
  - wb_write <= |grant.
  - On a grant, wb_data/wb_dest/wb_src load the granted slot; with no grant, wb_data/wb_dest/wb_src hold their previous values.
  - wb_write is a 1-cycle pulse per grant.
- Latency: handshake at edge of cycle t → slot full in cycle t+1 → if granted, wb_write=1 in cycle t+2. An ungranted slot delays its output by additional whole cycles.
- Conflict:
  - wb_conflict <= grant && (some other full slot j, not reloaded this edge, has dest == granted dest).
  - Writes are committed in grant order; no reordering or merging is done here.
- Throughput: one write per cycle sustained when any slot is full.

Test Plan:
- Reset: drive src_valid=all 1 with rst=1 for 3 cycles → src_ready=0, wb_write=0, pending=0; the first accept occurs on the edge after rst falls.
- Single source: src0 sends data 0xA5, dest 3 at edge t → in cycle t+2, wb_write=1, wb_data=0xA5, wb_dest=3, wb_src=0; in cycle t+3, wb_write=0.
- Fixed-priority starvation (mode 0, MAX_WAIT=4, NUM_SRC=2):
  - Stimulus: src0 streams continuously; src1 loads 0x3C, dest 5 once.
  - Required: src1 is passed over 4 consecutive cycles, then granted on the 5th.
  - Required: src0's grant is stalled that cycle, and src0_ready stays low until its slot drains.
- Round-robin (mode 1, NUM_SRC=3): all three sources stream continuously → wb_src sequence is 0,1,2,0,1,2; no gaps in wb_write.
- Conflict: src0 and src1 load dest 2 (0x11, 0x22) on the same edge → first output wb_src=0, data 0x11, wb_conflict=1; next cycle wb_src=1, data 0x22, wb_conflict=0.
- Reset mid-operation: both slots full, assert rst for 1 cycle → no wb_write during or after reset; pending=0.
